// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] IDX_NONE = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             busy;
    logic             timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_vld, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_vld, busy, timeout
    );

endinterface

// File: rtl/onehot_enc8.sv
// Combinational 8-bit one-hot to binary encoder; idx is IDX_NONE unless exactly one bit is set.
module onehot_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] oh,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    always_comb begin
        idx = IDX_NONE;
        vld = $onehot(oh);
        if (vld) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (oh[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, index and valid.
// Optional forced release after TIMEOUT_CYC busy cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter logic [IDX_W-1:0] PTR_INIT = 3'd0
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_8_if.slave  bus
);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [N_REQ-1:0] gnt_p1, gnt_n;
    logic [IDX_W-1:0] idx_p1, idx_n;
    logic             vld_p1, vld_n;
    logic             rel;
    logic             force_rel;

    logic [IDX_W-1:0] win, cand;
    logic             found;
    logic [N_REQ-1:0] win_oh;

    // Rotating-priority search starting at ptr
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && bus.req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign win_oh = found ? (N_REQ'(1) << win) : '0;
    assign rel    = bus.done | ~bus.req[idx_p1];

`ifdef ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TMR_W-1:0] timer;
    logic             timeout_p1;

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) timer <= '0;
        else                      timer <= timer + 1'b1;
    end

    assign force_rel = (state == BUSY) && !rel && (timer == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) timeout_p1 <= 1'b0;
        else     timeout_p1 <= force_rel;
    end

    assign bus.timeout = timeout_p1;
`else
    assign force_rel   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gnt_n   = gnt_p1;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_n   = win_oh;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (rel || force_rel) begin
                    gnt_n   = '0;
                    ptr_n   = idx_p1 + 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    onehot_enc8 u_enc (
        .oh  (gnt_n),
        .idx (idx_n),
        .vld (vld_n)
    );

    // Stage 1: registered grant, index and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= PTR_INIT;
            gnt_p1 <= '0;
            idx_p1 <= IDX_NONE;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gnt_p1 <= gnt_n;
            idx_p1 <= idx_n;
            vld_p1 <= vld_n;
        end
    end

    assign bus.gnt     = gnt_p1;
    assign bus.gnt_idx = idx_p1;
    assign bus.gnt_vld = vld_p1;
    assign bus.busy    = (state == BUSY);

endmodule
